sphn_input_conditioner: RTL and testbench
=========================================

Name: sphn_input_conditioner

Overview:
- Upstream of the pong game/VGA top. Conditions the five raw button pins: player-one up/down, player-two up/down, player-two-active.
- Per channel: 2-flop synchroniser, then counter-based debounce.
- Latches conflict-resolved move commands once per frame on the frame tick from the VGA timing stage, so paddle logic sees stable commands for a whole frame.
- Flags changes of the player-two-active mode with a pulse.

Parameters:
- DB_COUNT, 50000, consecutive pix_clk cycles a synchronised input must differ from its debounced value before the debounced value flips (about 2 ms at 25.175 MHz). Legal range is DB_COUNT >= 1.
- CNT_W, $clog2(DB_COUNT+1), debounce counter width. Derived; must not be overridden.

Ports:
- pix_clk  input  1  pixel clock; the only clock.
- pix_rst  input  1  synchronous reset, active-high.
- i_btn  input  5  raw asynchronous pins: [0] p1 up, [1] p1 down, [2] p2 up, [3] p2 down, [4] p2 active.
- i_frame_tick  input  1  one-cycle pulse from VGA timing, first line of vblank.
- o_p1_up  output  1  frame-latched player-one up command.
- o_p1_down  output  1  frame-latched player-one down command.
- o_p2_up  output  1  frame-latched player-two up command.
- o_p2_down  output  1  frame-latched player-two down command.
- o_p2_active  output  1  frame-latched two-player mode.
- o_mode_change  output  1  one-cycle pulse when o_p2_active changes value.
- o_btn_db  output  5  live debounced levels, for debug and test.

Behaviour:
- Reset: synchronous, active-high on pix_rst. All sync flops, debounced levels, counters and outputs go to 0. o_mode_change is 0 during reset and on the first cycle after reset. Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per channel, s1 <= i_btn and s2 <= s1. No logic between them.
- Debounce, per channel, with registers db and cnt:
  - If s2 == db: cnt <= 0.
  - Otherwise, if cnt == DB_COUNT-1: db <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than DB_COUNT cycles never reaches db, and any return to s2 == db restarts the count.
- Latency: a clean step on i_btn sampled at edge 0 appears on db (o_btn_db) after edge DB_COUNT+1. With DB_COUNT=1 this is edge 2, i.e. synchroniser latency only.
- Frame latch, updated only on cycles where i_frame_tick=1. The new values are visible on the cycle after the tick.
  - o_p1_up <= db[0] & ~db[1]; o_p1_down <= db[1] & ~db[0]. Both pressed gives no move.
  - o_p2_up <= db[4] & db[2] & ~db[3]; o_p2_down <= db[4] & db[3] & ~db[2]. Player-two commands are forced to 0 when not in two-player mode.
  - o_p2_active <= db[4].
  - A debounced change between ticks is invisible until the next tick. A change on the tick cycle itself is not captured; the tick uses db as registered before that edge.
- o_mode_change: registered, 1 for exactly the cycle in which o_p2_active shows its new value. Driven by (tick && db[4] != o_p2_active). No pulse if the mode is unchanged.
- Ticks on consecutive cycles are legal; each one re-latches.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Package sphn_input_pkg:
  - NUM_BTN = 5.
  - Index constants BTN_P1_UP=0, BTN_P1_DN=1, BTN_P2_UP=2, BTN_P2_DN=3, BTN_P2_ACT=4.
- Sub-module sphn_debounce:
  - One channel: synchroniser, counter and db.
  - Parameter DB_COUNT; ports pix_clk, pix_rst, i_raw, o_level.
  - Instantiated NUM_BTN times by a generate loop. Frame latch and conflict logic stay in the parent.

Test Plan (bench uses DB_COUNT=4):
- Reset: hold pix_rst 3 cycles with i_btn=5'b11111. Required: all outputs 0 during reset and on the cycle after; o_btn_db still 0 until 5 cycles after reset releases.
- Debounce latency: step i_btn[0] 0->1 at edge 0. Required: o_btn_db[0]=1 after edge 5, not before. A 3-cycle pulse on i_btn[1] gives o_btn_db[1]=0 throughout.
- Frame latch: db[0]=1, then pulse i_frame_tick. Required: o_p1_up=1 starting the next cycle. Drop i_btn[0]: o_p1_up stays 1 until the following tick, then 0.
- Conflict: db[0]=db[1]=1, then tick. Required: o_p1_up=0 and o_p1_down=0.
- Mode gating and pulse: db[2]=1 with db[4]=0, tick. Required: o_p2_up=0. Set db[4]=1, tick. Required: o_p2_up=1, o_p2_active=1 and o_mode_change=1 for exactly one cycle. A further tick gives no pulse.
- Mid-operation reset: assert pix_rst after 2 of 4 debounce counts. Required: counters clear; after release the full 4-cycle debounce plus 2-cycle sync is needed again.

Source files
------------

// File: rtl/sphn_input_pkg.sv
// Shared constants for the pong button conditioner: channel count and the
// bit position of each button within the raw and debounced vectors.
package sphn_input_pkg;

  localparam int NUM_BTN    = 5;

  localparam int BTN_P1_UP  = 0;
  localparam int BTN_P1_DN  = 1;
  localparam int BTN_P2_UP  = 2;
  localparam int BTN_P2_DN  = 3;
  localparam int BTN_P2_ACT = 4;

endpackage

// File: rtl/sphn_debounce.sv
// One button channel: two-flop synchroniser followed by a counter debounce.
// The level flips only after DB_COUNT consecutive cycles of disagreement.
module sphn_debounce #(
  parameter int DB_COUNT = 50000
) (
  input  logic pix_clk,
  input  logic pix_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = $clog2(DB_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             db_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Pure flop pair; nothing may sit between them or metastability leaks in.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= i_raw;
      s2_reg <= s1_reg;
    end
  end

  // Any cycle of agreement restarts the count, so short glitches never land.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      db_reg  <= 1'b0;
      cnt_reg <= '0;
    end else if (s2_reg == db_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      db_reg  <= s2_reg;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_level = db_reg;

endmodule

// File: rtl/sphn_input_conditioner.sv
// Conditions the five pong buttons and latches conflict-resolved move
// commands once per frame so paddle logic sees stable inputs all frame.
module sphn_input_conditioner
  import sphn_input_pkg::*;
#(
  parameter int DB_COUNT = 50000
) (
  input  logic               pix_clk,
  input  logic               pix_rst,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic               i_frame_tick,
  output logic               o_p1_up,
  output logic               o_p1_down,
  output logic               o_p2_up,
  output logic               o_p2_down,
  output logic               o_p2_active,
  output logic               o_mode_change,
  output logic [NUM_BTN-1:0] o_btn_db
);

  logic [NUM_BTN-1:0] db;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      sphn_debounce #(
        .DB_COUNT (DB_COUNT)
      ) u_debounce (
        .pix_clk (pix_clk),
        .pix_rst (pix_rst),
        .i_raw   (i_btn[gi]),
        .o_level (db[gi])
      );
    end
  endgenerate

  assign o_btn_db = db;

  logic p1_up_next;
  logic p1_down_next;
  logic p2_up_next;
  logic p2_down_next;

  // Opposing presses cancel; player two only moves in two-player mode.
  always_comb begin
    p1_up_next   = db[BTN_P1_UP] & ~db[BTN_P1_DN];
    p1_down_next = db[BTN_P1_DN] & ~db[BTN_P1_UP];
    p2_up_next   = db[BTN_P2_ACT] & db[BTN_P2_UP] & ~db[BTN_P2_DN];
    p2_down_next = db[BTN_P2_ACT] & db[BTN_P2_DN] & ~db[BTN_P2_UP];
  end

  logic p1_up_reg;
  logic p1_down_reg;
  logic p2_up_reg;
  logic p2_down_reg;
  logic p2_active_reg;
  logic mode_change_reg;

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      p1_up_reg       <= 1'b0;
      p1_down_reg     <= 1'b0;
      p2_up_reg       <= 1'b0;
      p2_down_reg     <= 1'b0;
      p2_active_reg   <= 1'b0;
      mode_change_reg <= 1'b0;
    end else if (i_frame_tick) begin
      p1_up_reg       <= p1_up_next;
      p1_down_reg     <= p1_down_next;
      p2_up_reg       <= p2_up_next;
      p2_down_reg     <= p2_down_next;
      p2_active_reg   <= db[BTN_P2_ACT];
      // Compared against the old latched mode so it rises with the new value.
      mode_change_reg <= (db[BTN_P2_ACT] != p2_active_reg);
    end else begin
      mode_change_reg <= 1'b0;
    end
  end

  assign o_p1_up       = p1_up_reg;
  assign o_p1_down     = p1_down_reg;
  assign o_p2_up       = p2_up_reg;
  assign o_p2_down     = p2_down_reg;
  assign o_p2_active   = p2_active_reg;
  assign o_mode_change = mode_change_reg;

endmodule

// File: tb/tb_sphn_input_conditioner.sv
// Directed bench for sphn_input_conditioner with DB_COUNT=4: reset, debounce
// latency and glitch rejection, frame latching, conflicts and mode gating.
module tb_sphn_input_conditioner;

  logic       pix_clk = 1'b0;
  logic       pix_rst;
  logic [4:0] i_btn;
  logic       i_frame_tick;
  logic       o_p1_up;
  logic       o_p1_down;
  logic       o_p2_up;
  logic       o_p2_down;
  logic       o_p2_active;
  logic       o_mode_change;
  logic [4:0] o_btn_db;

  int checks = 0;
  int errors = 0;

  sphn_input_conditioner #(
    .DB_COUNT (4)
  ) dut (
    .pix_clk       (pix_clk),
    .pix_rst       (pix_rst),
    .i_btn         (i_btn),
    .i_frame_tick  (i_frame_tick),
    .o_p1_up       (o_p1_up),
    .o_p1_down     (o_p1_down),
    .o_p2_up       (o_p2_up),
    .o_p2_down     (o_p2_down),
    .o_p2_active   (o_p2_active),
    .o_mode_change (o_mode_change),
    .o_btn_db      (o_btn_db)
  );

  always #5 pix_clk = ~pix_clk;

  // {mode_change, p2_active, p2_down, p2_up, p1_down, p1_up}
  function automatic logic [5:0] outs();
    return {o_mode_change, o_p2_active, o_p2_down, o_p2_up, o_p1_down, o_p1_up};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it; inputs change here too.
  task automatic step();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic frame_tick();
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
  endtask

  initial begin
    pix_rst      = 1'b1;
    i_btn        = 5'b11111;
    i_frame_tick = 1'b1;

    // Reset held three cycles with every pin pressed and a tick asserted.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_outs", 8'(outs()), 8'h00);
      chk("rst_db", 8'(o_btn_db), 8'h00);
    end
    pix_rst      = 1'b0;
    i_frame_tick = 1'b0;

    // Edges 0..4 after release: still zero; edge 5: all levels up.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_db_low", 8'(o_btn_db), 8'h00);
      chk("post_rst_outs", 8'(outs()), 8'h00);
    end
    step();
    chk("post_rst_db_high", 8'(o_btn_db), 8'h1f);

    // Release everything, then a clean step on p1 up.
    i_btn = 5'b00000;
    wait_cycles(6);
    chk("all_released", 8'(o_btn_db), 8'h00);

    i_btn = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("latency_early", 8'(o_btn_db[0]), 8'h00);
    end
    step();
    chk("latency_edge5", 8'(o_btn_db[0]), 8'h01);

    // Three-cycle glitch on p1 down must never reach the debounced level.
    i_btn = 5'b00011;
    wait_cycles(3);
    i_btn = 5'b00001;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch_rejected", 8'(o_btn_db), 8'h01);
    end

    // Frame latch: nothing visible until the tick, then p1 up.
    chk("pre_tick_outs", 8'(outs()), 8'h00);
    frame_tick();
    chk("tick_p1_up", 8'(outs()), 8'h01);

    // Release between ticks: latched command holds until the next tick.
    i_btn = 5'b00000;
    wait_cycles(7);
    chk("released_db", 8'(o_btn_db), 8'h00);
    chk("hold_p1_up", 8'(outs()), 8'h01);
    frame_tick();
    chk("tick_clear", 8'(outs()), 8'h00);

    // Both p1 buttons: no move.
    i_btn = 5'b00011;
    wait_cycles(6);
    chk("conflict_db", 8'(o_btn_db), 8'h03);
    frame_tick();
    chk("conflict_outs", 8'(outs()), 8'h00);

    // Only p1 down.
    i_btn = 5'b00010;
    wait_cycles(6);
    frame_tick();
    chk("p1_down", 8'(outs()), 8'h02);

    // p2 up without two-player mode is gated off.
    i_btn = 5'b00100;
    wait_cycles(6);
    chk("gate_db", 8'(o_btn_db), 8'h04);
    frame_tick();
    chk("p2_gated", 8'(outs()), 8'h00);

    // Enter two-player mode: p2 up, active, and a one-cycle mode pulse.
    i_btn = 5'b10100;
    wait_cycles(6);
    frame_tick();
    chk("mode_on", 8'(outs()), 8'h34);
    step();
    chk("mode_pulse_gone", 8'(outs()), 8'h14);
    frame_tick();
    chk("mode_no_repulse", 8'(outs()), 8'h14);

    // Consecutive ticks: both re-latch, still no pulse.
    i_btn = 5'b11000;
    wait_cycles(6);
    i_frame_tick = 1'b1;
    step();
    chk("b2b_tick1", 8'(outs()), 8'h18);
    step();
    chk("b2b_tick2", 8'(outs()), 8'h18);
    i_frame_tick = 1'b0;

    // Leave two-player mode: p2 down forced off, pulse on the exit too.
    i_btn = 5'b01000;
    wait_cycles(6);
    frame_tick();
    chk("mode_off", 8'(outs()), 8'h20);
    step();
    chk("mode_off_settle", 8'(outs()), 8'h00);

    // Mid-debounce reset: p1 up pressed, reset after two counts.
    i_btn = 5'b00000;
    wait_cycles(6);
    chk("pre_midrst_db", 8'(o_btn_db), 8'h00);
    i_btn = 5'b00001;
    wait_cycles(4);
    chk("midrst_partial", 8'(o_btn_db), 8'h00);
    pix_rst = 1'b1;
    wait_cycles(2);
    chk("midrst_db", 8'(o_btn_db), 8'h00);
    chk("midrst_outs", 8'(outs()), 8'h00);
    pix_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("midrst_relatch_low", 8'(o_btn_db), 8'h00);
    end
    step();
    chk("midrst_relatch_high", 8'(o_btn_db), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
